// File: rtl/bus_pkg.sv
// Shared types for the multiplexed 8085-style peripheral bus master:
// one-hot cycle-state encoding, the latched request record and a state-class helper.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    // One-hot bus cycle phases. TW is the READY wait state.
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        TW   = 6'b001000,
        T3   = 6'b010000,
        T4   = 6'b100000
    } bus_state_e;

    // Request captured on accept; the core may change its inputs afterwards.
    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    // Phases in which the RD_n/WR_n strobe is asserted.
    function automatic logic is_strobe(bus_state_e s);
        return (s == T2) || (s == TW) || (s == T3);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: cleared in T1, advanced on every entry into/stay in TW,
// terminal count flags that MAX_WAIT wait states have been spent.
module bus_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // Count TW cycles; the FSM leaves TW at terminal count so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_gen.sv
// Bus master that turns single core read/write requests into timed
// T1-T2-(TW)-T3-T4 bus cycles with ALE/CS_n/RD_n/WR_n and a muxed AD bus.
// All bus pins are registered from the next state and latched request, so
// neither req_* nor bus_rdy has a combinational path to the pins.
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// req_ready is high only in IDLE outside reset. rsp_valid is a one-cycle pulse
// in T4 with rsp_err/rsp_rdata valid alongside; no backpressure on responses.
module bus_cycle_gen
    import bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 ale,
    output logic                 cs_n,
    output logic                 rd_n,
    output logic                 wr_n,
    output logic [ADDR_W-DATA_W-1:0] addr_hi,
    output logic [DATA_W-1:0]    ad_out,
    output logic                 ad_oe,
    input  logic [DATA_W-1:0]    ad_in,
    input  logic                 bus_rdy,
    output logic [5:0]           dbg_state
);

    bus_state_e state_q;
    bus_state_e state_d;
    bus_req_t   req_q;
    bus_req_t   req_d;
    logic       accept;
    logic       timeout;
    logic       wait_tc;
    logic       tmr_clr;
    logic       tmr_en;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign dbg_state = state_q;

    // Next-state and request-capture logic; bus_rdy only matters in T2 and TW.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        timeout = 1'b0;
        if (accept) begin
            req_d.we    = req_we;
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
        end
        case (state_q)
            IDLE: if (accept) state_d = T1;
            T1:   state_d = T2;
            T2:   state_d = bus_rdy ? T3 : TW;
            TW: begin
                if (bus_rdy) begin
                    state_d = T3;
                end else if (wait_tc) begin
                    state_d = T4;
                    timeout = 1'b1;
                end
            end
            T3:   state_d = T4;
            T4:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter holds the number of TW cycles already entered, including the current one.
    assign tmr_clr = (state_q == T1);
    assign tmr_en  = (state_d == TW);

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (8)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (wait_tc)
    );

    // FSM state plus registered bus pins and response, decoded from the next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            ale       <= 1'b0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            addr_hi   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ale     <= (state_d == T1);
            cs_n    <= (state_d == IDLE);
            rd_n    <= !(is_strobe(state_d) && !req_d.we);
            wr_n    <= !(is_strobe(state_d) && req_d.we);
            ad_oe   <= (state_d == T1) || (is_strobe(state_d) && req_d.we);
            if (state_d == T1) begin
                ad_out <= req_d.addr[DATA_W-1:0];
            end else if (is_strobe(state_d) && req_d.we) begin
                ad_out <= req_d.wdata;
            end else begin
                ad_out <= '0;
            end
            if (state_d != IDLE) begin
                addr_hi <= req_d.addr[ADDR_W-1:DATA_W];
            end
            rsp_valid <= (state_d == T4);
            rsp_err   <= timeout;
            if (timeout) begin
                rsp_rdata <= '0;
            end else if ((state_q == T3) && !req_q.we) begin
                rsp_rdata <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Directed plus randomized bench for bus_cycle_gen. Expected pin activity is
// computed per transaction from its phase layout: T1, T2, tw wait states, T3
// (absent on timeout), T4, then IDLE.
module tb_bus_cycle_gen;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        ale;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  addr_hi;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  ad_in = '0;
    logic        bus_rdy = 1'b1;
    logic [5:0]  dbg_state;

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  exp_rdata = '0;

    bus_cycle_gen #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .ale       (ale),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .addr_hi   (addr_hi),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ad_in     (ad_in),
        .bus_rdy   (bus_rdy),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle cycles: nothing requested, so no response and the master stays ready.
    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_rdy = 1'($urandom_range(0, 1));
            ad_in   = 8'($urandom);
            @(negedge clk);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_req_ready", req_ready, 1);
        end
    endtask

    // One transaction; w = number of consecutive bus_rdy=0 samples starting at T2.
    // Called and returns at a negedge; with keep=1 req_valid stays high afterwards.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int w, input bit keep);
        bit tmo;
        bit strobe;
        int tw;
        int len;
        int guard;
        tmo = (w > MAX_WAIT);
        tw  = tmo ? MAX_WAIT : w;
        len = tmo ? 3 + tw : 4 + tw;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", req_ready, 1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        for (int c = 1; c <= len + 1; c++) begin
            strobe = (c >= 2) && (c <= len - 1);
            check("ale", ale, c == 1);
            check("cs_n", cs_n, !(c <= len));
            check("rd_n", rd_n, !(strobe && !we));
            check("wr_n", wr_n, !(strobe && we));
            check("ad_oe", ad_oe, (c == 1) || (strobe && we));
            if ((c == 1) || (strobe && we))
                check("ad_out", ad_out, (c == 1) ? addr[7:0] : wdata);
            if (c <= len)
                check("addr_hi", addr_hi, addr[15:8]);
            check("rsp_valid", rsp_valid, c == len);
            check("rsp_err", rsp_err, tmo && (c == len));
            check("req_ready", req_ready, c == len + 1);
            if (c == len) begin
                if (tmo) exp_rdata = 8'h00;
                else if (!we) exp_rdata = rdata;
            end
            if (c >= len)
                check("rsp_rdata", rsp_rdata, exp_rdata);
            if (c <= len) begin
                if (c >= 2 && c <= 1 + w) bus_rdy = 1'b0;
                else if (c == 2 + tw) bus_rdy = 1'b1;
                else bus_rdy = 1'($urandom_range(0, 1));
                ad_in = (!tmo && c == 3 + tw) ? rdata : 8'($urandom);
                if (c == 1) begin
                    req_valid = keep;
                    req_we    = 1'($urandom_range(0, 1));
                    req_addr  = 16'($urandom);
                    req_wdata = 8'($urandom);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic        r_we;
        logic [15:0] r_addr;
        logic [7:0]  r_wdata;
        logic [7:0]  r_rdata;
        int          r_w;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ale", ale, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_ad_oe", ad_oe, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_addr_hi", addr_hi, 0);
        check("rst_ad_out", ad_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);

        // Directed: plain read, plain write, read with 3 wait states
        run_txn(1'b0, 16'h12A5, 8'h00, 8'h3C, 0, 1'b0);
        idle(2);
        run_txn(1'b1, 16'h0040, 8'h5A, 8'h00, 0, 1'b0);
        idle(1);
        run_txn(1'b0, 16'h7E11, 8'h00, 8'hC7, 3, 1'b0);
        idle(1);

        // READY stuck low: timeout, then a normal read
        run_txn(1'b0, 16'hBEEF, 8'h00, 8'h99, 20, 1'b0);
        run_txn(1'b0, 16'h0102, 8'h00, 8'h6D, 1, 1'b0);
        // Write timeout clears rsp_rdata as well
        run_txn(1'b1, 16'h4433, 8'hF0, 8'h00, 16, 1'b0);
        idle(1);

        // req_valid held high across three requests
        run_txn(1'b0, 16'hA001, 8'h00, 8'h11, 0, 1'b1);
        run_txn(1'b1, 16'hA002, 8'h22, 8'h00, 0, 1'b1);
        run_txn(1'b0, 16'hA003, 8'h00, 8'h33, 2, 1'b0);
        idle(1);

        // Randomized transactions
        for (int k = 0; k < 24; k++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 16'($urandom);
            r_wdata = 8'($urandom);
            r_rdata = 8'($urandom);
            r_w     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 18))
                                                  : int'($urandom_range(0, 5));
            run_txn(r_we, r_addr, r_wdata, r_rdata, r_w, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a wait state
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h8001;
        @(negedge clk);                 // T1
        req_valid = 1'b0;
        bus_rdy   = 1'b1;
        @(negedge clk);                 // T2
        bus_rdy   = 1'b0;
        @(negedge clk);                 // TW
        check("mid_rd_n_in_tw", rd_n, 0);
        check("mid_cs_n_in_tw", cs_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_rd_n", rd_n, 1);
        check("mid_rst_wr_n", wr_n, 1);
        check("mid_rst_ale", ale, 0);
        check("mid_rst_ad_oe", ad_oe, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        exp_rdata = 8'h00;
        check("mid_post_ready", req_ready, 1);
        check("mid_post_rsp_valid", rsp_valid, 0);
        check("mid_post_rdata", rsp_rdata, exp_rdata);
        idle(3);
        run_txn(1'b0, 16'h5A5A, 8'h00, 8'hE1, 2, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
